// File: rtl/bp_stream_mmio_arbiter.sv
// bp_stream_mmio_arbiter
//
// Round-robin arbiter/sequencer that shares one outgoing MMIO stream link among
// num_req_p requesters. Each granted command goes out as an address beat followed
// by a data beat. The requester ID of every issued command is kept in an in-order
// tag FIFO so completions are steered back to the originator in issue order.
//
// Ports:
//   clk_i, reset_n_i           clock, asynchronous active-low reset
//   req_v_i/addr_i/data_i      per-requester command (packed, requester k at slot k)
//   req_yumi_o                 one-hot command-consumed strobe
//   resp_v_o / resp_ready_i    one-hot completion valid / per-requester ready
//   stream_v_o/data_o/ready_i  outgoing beat handshake
//   ack_v_i / ack_ready_o      host completion ack (ack feature only)
//
// Optional feature: define BP_STREAM_MMIO_ARB_ACK_EN to hold each response until
// the host has acknowledged it. Without it, responses are posted: released as soon
// as the tag FIFO is non-empty, ack_v_i is ignored and ack_ready_o is tied high.

module bp_stream_mmio_arbiter #(
    parameter int unsigned num_req_p           = 4,
    parameter int unsigned addr_width_p        = 32,
    parameter int unsigned stream_data_width_p = 32,
    parameter int unsigned tag_els_p           = 16
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [num_req_p-1:0]                  req_v_i,
    input  logic [num_req_p*addr_width_p-1:0]     req_addr_i,
    input  logic [num_req_p*stream_data_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]                  req_yumi_o,
    output logic [num_req_p-1:0]                  resp_v_o,
    input  logic [num_req_p-1:0]                  resp_ready_i,
    output logic                                  stream_v_o,
    output logic [stream_data_width_p-1:0]        stream_data_o,
    input  logic                                  stream_ready_i,
    input  logic                                  ack_v_i,
    output logic                                  ack_ready_o
);

    localparam int unsigned IdW  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned PtrW = (tag_els_p > 1) ? $clog2(tag_els_p) : 1;
    localparam int unsigned CntW = $clog2(tag_els_p + 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   grant_q, grant_d;
    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [IdW-1:0]   tag_mem_q [tag_els_p];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    logic             push, pop, full, ack_ok, resp_release;
    logic [IdW-1:0]   head_id;

    // ---------------------------------------------------------------------------
    // Round-robin pick: first valid requester at or after rr_ptr_q, wrapping.
    // ---------------------------------------------------------------------------
    logic             pick_found;
    logic [IdW-1:0]   pick_id;
    logic [IdW-1:0]   cand;

    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            cand = IdW'((32'(rr_ptr_q) + i) % num_req_p);
            if (!pick_found && req_v_i[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign full = (count_q == CntW'(tag_els_p));

    // ---------------------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        push     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found && !full) begin
                    grant_d = pick_id;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (stream_ready_i) state_d = StData;
            end
            StData: begin
                if (stream_ready_i) begin
                    push     = 1'b1;
                    rr_ptr_d = (grant_q == IdW'(num_req_p - 1)) ? '0 : grant_q + IdW'(1);
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // ---------------------------------------------------------------------------
    // Granted operand mux and address width adaptation
    // ---------------------------------------------------------------------------
    logic [addr_width_p-1:0]        addr_sel;
    logic [stream_data_width_p-1:0] data_sel;
    logic [stream_data_width_p-1:0] addr_ext;

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int k = 0; k < int'(num_req_p); k++) begin
            if (grant_q == IdW'(k)) begin
                addr_sel = req_addr_i[k*addr_width_p +: addr_width_p];
                data_sel = req_data_i[k*stream_data_width_p +: stream_data_width_p];
            end
        end
    end

    if (addr_width_p > stream_data_width_p) begin : g_addr_trunc
        logic [addr_width_p-stream_data_width_p-1:0] unused_addr_hi;
        assign unused_addr_hi = addr_sel[addr_width_p-1:stream_data_width_p];
        assign addr_ext       = addr_sel[stream_data_width_p-1:0];
    end else if (addr_width_p < stream_data_width_p) begin : g_addr_zext
        assign addr_ext = {{(stream_data_width_p - addr_width_p){1'b0}}, addr_sel};
    end else begin : g_addr_same
        assign addr_ext = addr_sel;
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        stream_v_o    = (state_q != StIdle);
        stream_data_o = '0;
        if (state_q == StAddr) stream_data_o = addr_ext;
        if (state_q == StData) stream_data_o = data_sel;
    end

    assign req_yumi_o = push ? ({{(num_req_p-1){1'b0}}, 1'b1} << grant_q) : '0;

    // ---------------------------------------------------------------------------
    // In-order tag FIFO
    // ---------------------------------------------------------------------------
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(tag_els_p - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign head_id      = tag_mem_q[rd_ptr_q];
    assign resp_release = (count_q != '0) && ack_ok;
    assign resp_v_o     = resp_release ? ({{(num_req_p-1){1'b0}}, 1'b1} << head_id) : '0;
    assign pop          = resp_release && resp_ready_i[head_id];

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) tag_mem_q[wr_ptr_q] <= grant_q;
    end

    // ---------------------------------------------------------------------------
    // Completion release
    // ---------------------------------------------------------------------------
`ifdef BP_STREAM_MMIO_ARB_ACK_EN
    logic [CntW-1:0] ack_cnt_q, ack_cnt_d;
    logic            ack_inc;

    // Acks are only accepted for commands already issued, so ack_cnt_q <= count_q.
    assign ack_ready_o = (ack_cnt_q < count_q);
    assign ack_inc     = ack_v_i && ack_ready_o;
    assign ack_ok      = (ack_cnt_q != '0);

    always_comb begin
        ack_cnt_d = ack_cnt_q;
        unique case ({ack_inc, pop})
            2'b10:   ack_cnt_d = ack_cnt_q + CntW'(1);
            2'b01:   ack_cnt_d = ack_cnt_q - CntW'(1);
            default: ack_cnt_d = ack_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ack_cnt_q <= '0;
        else            ack_cnt_q <= ack_cnt_d;
    end
`else
    logic unused_ack_v;
    assign unused_ack_v = ack_v_i;
    assign ack_ready_o  = 1'b1;
    assign ack_ok       = 1'b1;
`endif

endmodule

// File: tb/tb_bp_stream_mmio_arbiter.sv
module tb_bp_stream_mmio_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int SW = 32;
    localparam int TE = 16;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic [NR-1:0]     req_v_i;
    logic [NR*AW-1:0]  req_addr_i;
    logic [NR*SW-1:0]  req_data_i;
    logic [NR-1:0]     req_yumi_o;
    logic [NR-1:0]     resp_v_o;
    logic [NR-1:0]     resp_ready_i;
    logic              stream_v_o;
    logic [SW-1:0]     stream_data_o;
    logic              stream_ready_i;
    logic              ack_v_i;
    logic              ack_ready_o;

    bp_stream_mmio_arbiter #(
        .num_req_p          (NR),
        .addr_width_p       (AW),
        .stream_data_width_p(SW),
        .tag_els_p          (TE)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .req_v_i       (req_v_i),
        .req_addr_i    (req_addr_i),
        .req_data_i    (req_data_i),
        .req_yumi_o    (req_yumi_o),
        .resp_v_o      (resp_v_o),
        .resp_ready_i  (resp_ready_i),
        .stream_v_o    (stream_v_o),
        .stream_data_o (stream_data_o),
        .stream_ready_i(stream_ready_i),
        .ack_v_i       (ack_v_i),
        .ack_ready_o   (ack_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cmd(input int k, input logic [31:0] a, input logic [31:0] d);
        req_addr_i[k*AW +: AW] = a;
        req_data_i[k*SW +: SW] = d;
    endtask

    function automatic logic [31:0] addr_of(input int k);
        return req_addr_i[k*AW +: AW];
    endfunction

    function automatic logic [31:0] data_of(input int k);
        return req_data_i[k*SW +: SW];
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Spec rule: first valid requester at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [3:0] v, input int ptr);
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (ptr + i) % 4;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset_n_i      = 1'b0;
        req_v_i        = '0;
        stream_ready_i = 1'b0;
        resp_ready_i   = '0;
        ack_v_i        = 1'b0;
        #1;
        chk("reset_stream_v", stream_v_o, 0);
        chk("reset_stream_data", stream_data_o, 0);
        chk("reset_yumi", req_yumi_o, 0);
        chk("reset_resp_v", resp_v_o, 0);
`ifdef BP_STREAM_MMIO_ARB_ACK_EN
        chk("reset_ack_ready", ack_ready_o, 0);
`else
        chk("reset_ack_ready", ack_ready_o, 1);
`endif
        tick();
        tick();
        reset_n_i = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  req_v;
        logic        sr;
        logic [3:0]  rr;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ey;
        logic [3:0]  er;
    } vec_t;

    vec_t vecs [17];

    // Random-phase model state
    logic [3:0]  rv, prev_req_v, yumi_last, exp_resp;
    int          mq[$];
    int          rr_m, prev_cnt, g_cur, issued;
    logic        prev_sv, prev_acc, in_data, acc;
    logic [31:0] prev_sd;
    int          gq[$];
    int          rq[$];

    initial begin
        req_addr_i = '0;
        req_data_i = '0;
        do_reset();

`ifndef BP_STREAM_MMIO_ARB_ACK_EN
        // ---------------- Table-driven directed vectors ----------------
        set_cmd(2, 32'h8000_0010, 32'hDEAD_BEEF);
        set_cmd(0, 32'h1111_0000, 32'h2222_0000);
        vecs[0]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000};
        vecs[1]  = '{4'b0100, 1'b1, 4'b0000, 1'b1, 32'h8000_0010, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b0100, 1'b1, 4'b0000, 1'b1, 32'hDEAD_BEEF, 4'b0100, 4'b0000};
        vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0100};
        vecs[4]  = '{4'b0000, 1'b1, 4'b1111, 1'b0, 32'h0,         4'b0000, 4'b0100};
        vecs[5]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000};
        for (int i = 6; i <= 10; i++)
            vecs[i] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 32'h1111_0000, 4'b0000, 4'b0000};
        vecs[11] = '{4'b0001, 1'b1, 4'b0000, 1'b1, 32'h1111_0000, 4'b0000, 4'b0000};
        vecs[12] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 32'h2222_0000, 4'b0000, 4'b0000};
        vecs[13] = '{4'b0001, 1'b1, 4'b0000, 1'b1, 32'h2222_0000, 4'b0001, 4'b0000};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0001};
        vecs[15] = '{4'b0000, 1'b0, 4'b0001, 1'b0, 32'h0,         4'b0000, 4'b0001};
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000};
        for (int i = 0; i < 17; i++) begin
            req_v_i        = vecs[i].req_v;
            stream_ready_i = vecs[i].sr;
            resp_ready_i   = vecs[i].rr;
            #1;
            chk($sformatf("vec%0d_stream_v", i), stream_v_o, vecs[i].ev);
            chk($sformatf("vec%0d_stream_data", i), stream_data_o, vecs[i].ed);
            chk($sformatf("vec%0d_yumi", i), req_yumi_o, vecs[i].ey);
            chk($sformatf("vec%0d_resp_v", i), resp_v_o, vecs[i].er);
            tick();
        end

        // ---------------- Round-robin order, all requesters valid ----------------
        do_reset();
        for (int k = 0; k < NR; k++) set_cmd(k, 32'hA000_0000 + k, 32'hB000_0000 + k);
        req_v_i = 4'b1111; stream_ready_i = 1'b1; resp_ready_i = 4'b1111;
        gq.delete(); rq.delete();
        for (int c = 0; c < 60 && (gq.size() < 5 || rq.size() < 5); c++) begin
            #1;
            if (req_yumi_o != 0) gq.push_back(oh_idx(req_yumi_o));
            if (resp_v_o != 0) rq.push_back(oh_idx(resp_v_o));
            tick();
        end
        chk("rr_grant_count", gq.size() >= 5, 1);
        chk("rr_resp_count", rq.size() >= 5, 1);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk($sformatf("rr_grant%0d", i), gq[i], i % 4);
        for (int i = 0; i < 5 && i < rq.size(); i++) chk($sformatf("rr_resp%0d", i), rq[i], i % 4);

        // ---------------- Tag FIFO full ----------------
        do_reset();
        req_v_i = 4'b1111; stream_ready_i = 1'b1; resp_ready_i = 4'b0000;
        issued = 0;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (req_yumi_o != 0) issued++;
            tick();
        end
        chk("full_issued", issued, TE);
        chk("full_head", resp_v_o, 4'b0001);
        resp_ready_i = 4'b0001;
        tick();
        resp_ready_i = 4'b0000;
        issued = 0;
        g_cur  = -1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (req_yumi_o != 0) begin issued++; g_cur = oh_idx(req_yumi_o); end
            tick();
        end
        chk("full_after_pop_issued", issued, 1);
        chk("full_after_pop_grant", g_cur, 0);
        chk("full_after_pop_head", resp_v_o, 4'b0010);

        // ---------------- Reset during DATA ----------------
        do_reset();
        set_cmd(0, 32'h0000_0A00, 32'h0000_0D00);
        set_cmd(2, 32'h0000_2A00, 32'h0000_2D00);
        set_cmd(3, 32'h0000_3A00, 32'h0000_3D00);
        req_v_i = 4'b0001; stream_ready_i = 1'b1; resp_ready_i = 4'b0000;
        tick(); tick(); tick();
        req_v_i = 4'b0100;
        tick(); tick();
        #1;
        chk("mid_pre_data", stream_data_o, 32'h0000_2D00);
        reset_n_i = 1'b0;
        #1;
        chk("mid_stream_v", stream_v_o, 0);
        chk("mid_stream_data", stream_data_o, 0);
        chk("mid_yumi", req_yumi_o, 0);
        chk("mid_resp_v", resp_v_o, 0);
        tick();
        reset_n_i = 1'b1;
        req_v_i   = 4'b1001;
        tick();
        #1;
        chk("mid_rr_ptr_zero", stream_data_o, 32'h0000_0A00);
        chk("mid_fifo_empty", resp_v_o, 0);
        tick(); tick();

        // ---------------- Randomized against reference model ----------------
        do_reset();
        rv = '0; yumi_last = '0; prev_req_v = '0; mq.delete(); rr_m = 0; prev_cnt = 0;
        prev_sv = 1'b0; prev_acc = 1'b0; prev_sd = '0; in_data = 1'b0; g_cur = -1;
        for (int c = 0; c < 3000; c++) begin
            rv = rv & ~yumi_last;
            for (int k = 0; k < NR; k++) begin
                if (!rv[k] && $urandom_range(0, 3) == 0) begin
                    rv[k] = 1'b1;
                    set_cmd(k, $urandom, $urandom);
                end
            end
            req_v_i        = rv;
            stream_ready_i = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NR; k++) resp_ready_i[k] = ($urandom_range(0, 3) == 0);
            #1;
            exp_resp = (mq.size() != 0) ? (4'b0001 << mq[0]) : 4'b0000;
            chk("rnd_resp_v", resp_v_o, exp_resp);
            if (prev_sv && !prev_acc) begin
                chk("rnd_hold_v", stream_v_o, 1);
                chk("rnd_hold_data", stream_data_o, prev_sd);
            end
            acc = stream_v_o && stream_ready_i;
            if (stream_v_o && !prev_sv) begin
                g_cur = rr_pick(prev_req_v, rr_m);
                chk("rnd_grant_valid", g_cur >= 0, 1);
                chk("rnd_grant_not_full", prev_cnt < TE, 1);
                if (g_cur >= 0) chk("rnd_addr_beat", stream_data_o, addr_of(g_cur));
            end
            if (acc && in_data && g_cur >= 0) begin
                chk("rnd_data_beat", stream_data_o, data_of(g_cur));
                chk("rnd_yumi", req_yumi_o, 4'b0001 << g_cur);
            end else begin
                chk("rnd_no_yumi", req_yumi_o, 0);
            end
            prev_cnt = mq.size();
            if (exp_resp != 0 && resp_ready_i[mq[0]]) void'(mq.pop_front());
            if (acc && in_data) begin
                if (g_cur >= 0) begin
                    mq.push_back(g_cur);
                    rr_m = (g_cur + 1) % NR;
                end
                in_data = 1'b0;
            end else if (acc) begin
                in_data = 1'b1;
            end
            prev_req_v = rv;
            prev_sv    = stream_v_o;
            prev_acc   = acc;
            prev_sd    = stream_data_o;
            yumi_last  = req_yumi_o;
            tick();
        end
`else
        // ---------------- Ack-gated responses ----------------
        for (int k = 0; k < NR; k++) set_cmd(k, 32'hC000_0000 + k, 32'hD000_0000 + k);
        rv = 4'b0111; stream_ready_i = 1'b1; resp_ready_i = 4'b1111;
        issued = 0;
        for (int c = 0; c < 30 && issued < 3; c++) begin
            req_v_i = rv;
            #1;
            chk("ack_no_resp_yet", resp_v_o, 0);
            if (req_yumi_o != 0) issued++;
            rv = rv & ~req_yumi_o;
            tick();
        end
        req_v_i = '0;
        chk("ack_issued", issued, 3);
        tick();
        chk("ack_held_resp", resp_v_o, 0);
        chk("ack_ready_pending", ack_ready_o, 1);
        resp_ready_i = 4'b0000;
        ack_v_i      = 1'b1;
        tick();
        ack_v_i = 1'b0;
        #1;
        chk("ack_first_resp", resp_v_o, 4'b0001);
        ack_v_i = 1'b1; resp_ready_i = 4'b1111;
        tick();
        ack_v_i = 1'b0;
        #1;
        chk("ack_pop_same_cycle", resp_v_o, 4'b0010);
        tick();
        #1;
        chk("ack_exhausted", resp_v_o, 0);
        chk("ack_ready_last", ack_ready_o, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_stream_mmio_arbiter.md
# bp_stream_mmio_arbiter

Round-robin arbiter and sequencer that shares one outgoing MMIO stream link among several requesters (per-core I/O command channels). It serializes each granted command as an address beat followed by a data beat on the stream, records the requester ID of every issued command in an in-order tag FIFO, and steers the completion response back to the originating requester. It sits between the per-core I/O command ports and the single stream-MMIO serializer/host link.

## Interface
Parameters:
- num_req_p, 4: number of requesters; must be ≥2.
- addr_width_p, 32: command address width.
- stream_data_width_p, 32: stream beat width; also the command data width.
- tag_els_p, 16: depth of the outstanding-command tag FIFO.

Ports:
- clk_i  in  1  clock; all state on the rising edge.
- reset_n_i  in  1  reset, asynchronous assert, active-low; release synchronized externally.
- req_v_i  in  num_req_p  per-requester command valid.
- req_addr_i  in  num_req_p*addr_width_p  packed addresses; requester k at [k*addr_width_p +: addr_width_p].
- req_data_i  in  num_req_p*stream_data_width_p  packed write data, same packing.
- req_yumi_o  out  num_req_p  one-hot; command consumed this cycle.
- resp_v_o  out  num_req_p  one-hot; completion pending for requester k.
- resp_ready_i  in  num_req_p  per-requester completion ready.
- stream_v_o  out  1  outgoing beat valid.
- stream_data_o  out  stream_data_width_p  outgoing beat.
- stream_ready_i  in  1  link accepts beat.
- ack_v_i  in  1  host completion acknowledgement (used only with ack feature).
- ack_ready_o  out  1  ack accepted.

## Operation
- FSM states: IDLE, ADDR, DATA; reset state IDLE.
- IDLE: if any req_v_i set and tag FIFO count < tag_els_p, pick first set requester at or after rr_ptr (wrapping), register grant_r, go to ADDR. Otherwise hold.
- ADDR: stream_v_o=1, stream_data_o=req_addr_i[grant_r] zero-extended or truncated to stream_data_width_p. On stream_ready_i go to DATA.
- DATA: stream_v_o=1, stream_data_o=req_data_i[grant_r]. On stream_ready_i: req_yumi_o[grant_r]=1, push grant_r into tag FIFO, rr_ptr ← grant_r+1 modulo num_req_p, go to IDLE.
- Requesters hold req_v_i/addr/data stable from assertion until yumi; the arbiter does not re-check req_v_i after grant.
- Response: when tag FIFO non-empty (and release condition met, see Configuration), resp_v_o[head_id]=1; pop when resp_ready_i[head_id]. Responses return strictly in issue order; a stalled head blocks others.
- Tag FIFO supports simultaneous push and pop in one cycle, including at full (pop frees slot, push accepted) and empty (push not visible until next cycle).
- Full: no new grant while count == tag_els_p; an in-flight command already in ADDR/DATA always completes.

## Timing
- Reset values: stream_v_o=0, stream_data_o=0, req_yumi_o=0, resp_v_o=0, ack_ready_o per Configuration, rr_ptr=0, FIFO empty, ack counter 0.
- req_v_i at cycle 0 (IDLE) → address beat at cycle 1 → data beat cycle 2 (stream_ready_i held 1) with req_yumi_o → resp_v_o at cycle 3 (posted mode).
- Peak throughput: one command per 3 cycles.
- stream_v_o never drops once asserted until the beat is accepted; stream_data_o stable while stalled.
- Reset asserted mid-command: everything clears immediately; no yumi issued, partial beat lost; link partner is reset together.

## Configuration
- BP_STREAM_MMIO_ARB_ACK_EN defined: a counter (0..tag_els_p) counts received acks; ack_ready_o = (ack count < FIFO count); ack_v_i&ack_ready_o increments. Response for head released only when ack count >0; pop decrements (simultaneous ack and pop leave count unchanged). ack_ready_o resets to 0.
- Not defined (posted mode): response released as soon as FIFO non-empty; ack_v_i ignored; ack_ready_o tied 1.

## Test plan
- Single requester 2, addr 0x8000_0010, data 0xDEAD_BEEF, stream ready 1 → beats 0x8000_0010 then 0xDEAD_BEEF at cycles 1,2; req_yumi_o=4'b0100 at cycle 2; resp_v_o=4'b0100 at cycle 3.
- All 4 requesters valid continuously → grant order 0,1,2,3,0; responses in same order.
- stream_ready_i low 5 cycles during ADDR → stream_v_o and address held stable; no yumi until data beat accepted.
- resp_ready_i all 0, 17 commands offered (tag_els_p=16) → exactly 16 issued; 17th issued only after one response popped.
- ACK_EN: 3 commands issued, no ack → resp_v_o=0, ack_ready_o=1; one ack → one response from first requester; ack+pop same cycle keeps count.
- reset_n_i low during DATA state → all outputs 0 same cycle, FIFO empty, rr_ptr 0 after release.
